trip_computer: RTL and testbench

- Consumes the wheel-sensor input and the `sec_pulse` / `half_sec_cum` outputs of the timing stage.
- Produces trip distance in metres and average trip speed in 0.1 km/h units, for the display stage.
- Distance accumulates continuously from debounced wheel edges.
- Average speed is recomputed once per second by an iterative restoring divider FSM.

---
 rtl/bike_pkg.sv | 11 +
 rtl/seq_divider.sv | 59 +++++
 rtl/trip_computer.sv | 122 ++++++++++++
 tb/tb_trip_computer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// Shared constants and types for the bike trip computer.
// No logic: scale factors, speed ceiling and the trip FSM state encoding.
package bike_pkg;
    localparam int MM_PER_M     = 1000;
    localparam int KMH10_FACTOR = 72;   // metres per half-second -> 0.1 km/h
    localparam int SPD_MAX_DEF  = 999;
    localparam int DIST_W_DEF   = 20;

    typedef enum logic [1:0] {IDLE, DIV, DONE} trip_state_t;
    typedef logic [DIST_W_DEF-1:0] dist_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; DVD_W cycles after start.
// done is high during the final iteration cycle; quotient is valid the cycle after.
module seq_divider #(
    parameter int DVD_W = 27,
    parameter int DVS_W = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int CNT_W = $clog2(DVD_W);

    logic [CNT_W-1:0] cnt;
    logic [DVS_W:0]   rem;
    logic [DVS_W-1:0] dvs;
    logic [DVS_W+1:0] rem_shift;
    logic [DVS_W:0]   trial;
    logic             fits;

    // quotient doubles as the dividend shift register: its MSB feeds the remainder
    always_comb begin
        rem_shift = {rem, quotient[DVD_W-1]};
        fits      = rem_shift >= {2'b00, dvs};
        trial     = rem_shift[DVS_W:0] - {1'b0, dvs};
    end

    assign done = busy && (cnt == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start && !busy) begin
            quotient <= dividend;
            dvs      <= divisor;
            rem      <= '0;
            cnt      <= CNT_W'(DVD_W - 1);
            busy     <= 1'b1;
        end else if (busy) begin
            rem      <= fits ? trial : rem_shift[DVS_W:0];
            quotient <= {quotient[DVD_W-2:0], fits};
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/trip_computer.sv
// Trip distance from debounced wheel edges, and average speed recomputed each second.
// avg_valid follows a sampled sec_pulse by DVD_W+1 edges (1 edge for a zero elapsed time).
module trip_computer
    import bike_pkg::*;
#(
    parameter int CIRC_MM = 2133,
    parameter int DIST_W  = 20,
    parameter int CUM_W   = 19,
    parameter int LOCKOUT = 8,
    parameter int SPD_MAX = SPD_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wheel_in,
    input  logic              trip_clear,
    input  logic              sec_pulse,
    input  logic [CUM_W-1:0]  half_sec_cum,
    output logic [DIST_W-1:0] dist_m,
    output logic [9:0]        avg_speed,
    output logic              avg_valid,
    output logic              busy
);
    localparam int DVD_W  = DIST_W + 7;
    localparam int LOCK_W = $clog2(LOCKOUT);

    logic              sync1, sync2, sync2_d;
    logic              rise, accept, drain;
    logic [LOCK_W-1:0] lock_cnt;
    logic [12:0]       mm_acc;

    assign rise   = sync2 & ~sync2_d;
    assign accept = rise && (lock_cnt == '0);
    assign drain  = mm_acc >= 13'(MM_PER_M);

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync2_d  <= 1'b0;
            lock_cnt <= '0;
            mm_acc   <= '0;
            dist_m   <= '0;
        end else begin
            sync1   <= wheel_in;
            sync2   <= sync1;
            sync2_d <= sync2;
            if (accept)
                lock_cnt <= LOCK_W'(LOCKOUT - 1);
            else if (lock_cnt != '0)
                lock_cnt <= lock_cnt - 1'b1;
            // drain keeps running at saturation so mm_acc never overflows
            if (trip_clear) begin
                mm_acc <= '0;
                dist_m <= '0;
            end else begin
                mm_acc <= mm_acc + (accept ? 13'(CIRC_MM) : 13'd0)
                                 - (drain  ? 13'(MM_PER_M) : 13'd0);
                if (drain && dist_m != '1)
                    dist_m <= dist_m + 1'b1;
            end
        end
    end

    trip_state_t      state;
    logic             start, div_busy, div_done, zero_div;
    logic [DVD_W-1:0] dividend, quotient;

    assign dividend = DVD_W'(dist_m) * DVD_W'(KMH10_FACTOR);
    assign start    = (state == IDLE) && sec_pulse && !trip_clear && (half_sec_cum != '0);

    seq_divider #(.DVD_W(DVD_W), .DVS_W(CUM_W)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (trip_clear),
        .dividend (dividend),
        .divisor  (half_sec_cum),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            avg_speed <= '0;
            avg_valid <= 1'b0;
            busy      <= 1'b0;
            zero_div  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (trip_clear) begin
                state     <= IDLE;
                busy      <= 1'b0;
                avg_speed <= '0;
            end else begin
                case (state)
                    IDLE: if (sec_pulse) begin
                        zero_div <= (half_sec_cum == '0);
                        busy     <= (half_sec_cum != '0);
                        state    <= (half_sec_cum == '0) ? DONE : DIV;
                    end
                    DIV: if (div_done || !div_busy) begin
                        busy  <= 1'b0;
                        state <= div_done ? DONE : IDLE;
                    end
                    DONE: begin
                        if (zero_div)
                            avg_speed <= '0;
                        else if (quotient > DVD_W'(SPD_MAX))
                            avg_speed <= 10'(SPD_MAX);
                        else
                            avg_speed <= quotient[9:0];
                        avg_valid <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trip_computer.sv
// Randomized bench for trip_computer: reference model of distance/speed plus a scoreboard queue.
module tb_trip_computer;
    localparam int CIRC   = 2133;
    localparam int DIST_W = 20;
    localparam int CUM_W  = 19;
    localparam int LAT    = 29;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              wheel_in = 1'b0;
    logic              trip_clear = 1'b0;
    logic              sec_pulse = 1'b0;
    logic [CUM_W-1:0]  half_sec_cum = '0;
    logic [DIST_W-1:0] dist_m;
    logic [9:0]        avg_speed;
    logic              avg_valid;
    logic              busy;

    int     checks = 0;
    int     passed = 0;
    int     cyc = 0;
    longint total_mm = 0;
    int     exp_spd_q[$];
    int     exp_cyc_q[$];

    trip_computer dut (
        .clock        (clock),
        .reset        (reset),
        .wheel_in     (wheel_in),
        .trip_clear   (trip_clear),
        .sec_pulse    (sec_pulse),
        .half_sec_cum (half_sec_cum),
        .dist_m       (dist_m),
        .avg_speed    (avg_speed),
        .avg_valid    (avg_valid),
        .busy         (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: every avg_valid must match the oldest outstanding request.
    always @(negedge clock) begin
        if (avg_valid) begin
            if (exp_spd_q.size() == 0) begin
                check("unexpected_avg_valid", 1, 0);
            end else begin
                check("avg_speed", avg_speed, exp_spd_q.pop_front());
                check("avg_latency", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    function automatic int model_dist();
        return int'(total_mm / 1000);
    endfunction

    function automatic int model_speed(input int half);
        longint q;
        if (half == 0) return 0;
        q = longint'(model_dist()) * 72 / half;
        return (q > 999) ? 999 : int'(q);
    endfunction

    task automatic wheel_pulse(input int gap, input bit bounce);
        wheel_in = 1'b1;
        tick(1);
        if (bounce) begin
            wheel_in = 1'b0;
            tick(1);
            wheel_in = 1'b1;
        end
        tick(3);
        wheel_in = 1'b0;
        tick(gap);
        total_mm += CIRC;
    endtask

    task automatic request_avg(input int half, input bit expect_out);
        half_sec_cum = CUM_W'(half);
        sec_pulse    = 1'b1;
        if (expect_out) begin
            exp_spd_q.push_back(model_speed(half));
            exp_cyc_q.push_back(cyc + ((half == 0) ? 2 : LAT));
        end
        tick(1);
        sec_pulse = 1'b0;
    endtask

    task automatic wait_results();
        int budget = 80;
        while (exp_spd_q.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (exp_spd_q.size() > 0) begin
            check("avg_timeout", exp_spd_q.size(), 0);
            exp_spd_q.delete();
            exp_cyc_q.delete();
        end
        tick(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        check("reset_dist", dist_m, 0);
        check("reset_speed", avg_speed, 0);
        check("reset_valid", avg_valid, 0);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        tick(2);

        // Ten clean pulses, then a 2-second average.
        for (int i = 0; i < 10; i++) wheel_pulse(20, 1'b0);
        tick(10);
        check("dist_clean", dist_m, model_dist());
        request_avg(4, 1'b1);
        wait_results();

        // Contact bounce: second rising edge inside lockout is dropped.
        wheel_pulse(20, 1'b1);
        tick(10);
        check("dist_bounce", dist_m, model_dist());

        // Randomized rounds, sometimes with an ignored second strobe while busy.
        for (int r = 0; r < 10; r++) begin
            int npulse = $urandom_range(0, 6);
            int half;
            for (int p = 0; p < npulse; p++)
                wheel_pulse($urandom_range(10, 20), 1'($urandom_range(0, 1)));
            tick(10);
            check("dist_rand", dist_m, model_dist());
            case ($urandom_range(0, 3))
                0:       half = 0;
                1:       half = $urandom_range(1, 3);
                default: half = $urandom_range(1, 5000);
            endcase
            request_avg(half, 1'b1);
            if (half != 0 && $urandom_range(0, 2) == 0) begin
                tick(4);
                check("busy_mid_div", busy, 1);
                request_avg($urandom_range(1, 100), 1'b0);
            end
            wait_results();
        end

        // Saturation to the speed ceiling, then zero elapsed time.
        while (model_dist() < 30) wheel_pulse(12, 1'b0);
        tick(10);
        check("dist_sat", dist_m, model_dist());
        request_avg(2, 1'b1);
        wait_results();
        request_avg(0, 1'b1);
        wait_results();

        // trip_clear ten cycles into a division aborts it.
        request_avg(7, 1'b0);
        tick(9);
        check("busy_before_clear", busy, 1);
        trip_clear = 1'b1;
        tick(1);
        trip_clear = 1'b0;
        total_mm = 0;
        check("clear_busy", busy, 0);
        check("clear_dist", dist_m, 0);
        check("clear_speed", avg_speed, 0);
        tick(40);

        // Reset mid-division with a non-zero trip.
        while (model_dist() < 50) wheel_pulse(12, 1'b0);
        tick(10);
        check("dist_pre_reset", dist_m, model_dist());
        request_avg(3, 1'b1);
        wait_results();
        request_avg(5, 1'b0);
        tick(10);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        total_mm = 0;
        check("rst_dist", dist_m, 0);
        check("rst_speed", avg_speed, 0);
        check("rst_valid", avg_valid, 0);
        check("rst_busy", busy, 0);
        tick(40);
        request_avg(10, 1'b1);
        wait_results();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
